// File: rtl/sector_timing_ctrl.sv
// Rotational timing sequencer: spin-up delay, sector/index marks, sector address,
// and single-sector access windows, all advanced by a 1 us clock enable.
module sector_timing_ctrl #(
  parameter int SECTORS_PER_REV = 12,
  parameter int SECTOR_USEC     = 3333,
  parameter int PULSE_USEC      = 5,
  parameter int INDEX_LEAD_USEC = 600,
  parameter int GUARD_USEC      = 40,
  parameter int SPINUP_USEC     = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clkenbl_1usec,
  input  logic       spin_enable,
  input  logic       access_req,
  input  logic [3:0] access_sector,
  output logic       drive_ready,
  output logic       sector_pulse,
  output logic       index_pulse,
  output logic [3:0] sector_address,
  output logic       sector_start,
  output logic       access_busy,
  output logic       access_gate,
  output logic       access_done,
  output logic       access_error
);

  localparam int               SPIN_W      = $clog2(SPINUP_USEC + 1);
  localparam logic [SPIN_W-1:0] SPIN_LAST  = SPIN_W'(SPINUP_USEC - 1);
  localparam logic [11:0]      SECTOR_LAST = 12'(SECTOR_USEC - 1);
  localparam logic [11:0]      PULSE_END   = 12'(PULSE_USEC);
  localparam logic [11:0]      INDEX_START = 12'(SECTOR_USEC - INDEX_LEAD_USEC);
  localparam logic [11:0]      INDEX_END   = 12'(SECTOR_USEC - INDEX_LEAD_USEC + PULSE_USEC);
  localparam logic [11:0]      GATE_END    = 12'(SECTOR_USEC - GUARD_USEC);
  localparam logic [3:0]       SECTOR_MAX  = 4'(SECTORS_PER_REV - 1);

  typedef enum logic [1:0] {S_IDLE, S_SPINUP, S_RUN} rot_state_t;
  typedef enum logic [1:0] {A_IDLE, A_WAIT, A_GATE} acc_state_t;

  rot_state_t        r_state, w_state_next;
  acc_state_t        r_acc_state, w_acc_next;
  logic [11:0]       r_count, w_count_next;
  logic [SPIN_W-1:0] r_spin, w_spin_next;
  logic [3:0]        r_sector, w_sector_next;
  logic [3:0]        r_target, w_target_next;
  logic              r_wrap, w_wrap_next;
  logic              w_run, w_accept, w_error_next, w_done_next;

  assign w_run    = spin_enable && (r_state == S_RUN);
  assign w_accept = w_run && (access_sector <= SECTOR_MAX);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_state_next  = r_state;
    w_count_next  = r_count;
    w_spin_next   = r_spin;
    w_sector_next = r_sector;
    w_wrap_next   = 1'b0;
    w_acc_next    = r_acc_state;
    w_target_next = r_target;
    w_error_next  = 1'b0;
    w_done_next   = 1'b0;

    case (r_state)
      S_IDLE: w_state_next = S_SPINUP;
      S_SPINUP:
        if (clkenbl_1usec) begin
          if (r_spin == SPIN_LAST) begin
            w_state_next  = S_RUN;
            w_spin_next   = '0;
            w_count_next  = '0;
            w_sector_next = '0;
            w_wrap_next   = 1'b1;
          end else begin
            w_spin_next = r_spin + SPIN_W'(1);
          end
        end
      S_RUN:
        if (clkenbl_1usec) begin
          if (r_count == SECTOR_LAST) begin
            w_count_next  = '0;
            w_sector_next = (r_sector == SECTOR_MAX) ? 4'd0 : r_sector + 4'd1;
            w_wrap_next   = 1'b1;
          end else begin
            w_count_next = r_count + 12'd1;
          end
        end
      default: w_state_next = S_IDLE;
    endcase

    // r_wrap marks the first clock of a new sector, so a window only ever opens at a sector start.
    case (r_acc_state)
      A_IDLE:
        if (access_req) begin
          if (w_accept) begin
            w_acc_next    = A_WAIT;
            w_target_next = access_sector;
          end else begin
            w_error_next = 1'b1;
          end
        end
      A_WAIT:
        if (r_wrap && (r_sector == r_target)) w_acc_next = A_GATE;
      A_GATE:
        if (r_count == GATE_END) begin
          w_acc_next  = A_IDLE;
          w_done_next = 1'b1;
        end
      default: w_acc_next = A_IDLE;
    endcase

    if (!spin_enable) begin
      w_state_next  = S_IDLE;
      w_count_next  = '0;
      w_spin_next   = '0;
      w_sector_next = '0;
      w_wrap_next   = 1'b0;
      w_acc_next    = A_IDLE;
      w_target_next = '0;
      w_done_next   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_acc_state    <= A_IDLE;
      r_count        <= '0;
      r_spin         <= '0;
      r_sector       <= '0;
      r_target       <= '0;
      r_wrap         <= 1'b0;
      drive_ready    <= 1'b0;
      sector_pulse   <= 1'b0;
      index_pulse    <= 1'b0;
      sector_address <= '0;
      sector_start   <= 1'b0;
      access_busy    <= 1'b0;
      access_gate    <= 1'b0;
      access_done    <= 1'b0;
      access_error   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_acc_state <= w_acc_next;
      r_count     <= w_count_next;
      r_spin      <= w_spin_next;
      r_sector    <= w_sector_next;
      r_target    <= w_target_next;
      r_wrap      <= w_wrap_next;
      // Decodes read the current count/sector, giving a uniform one-clock lag on all marks.
      drive_ready    <= w_run;
      sector_pulse   <= w_run && (r_count < PULSE_END);
      index_pulse    <= w_run && (r_sector == SECTOR_MAX) &&
                        (r_count >= INDEX_START) && (r_count < INDEX_END);
      sector_address <= w_run ? r_sector : 4'd0;
      sector_start   <= w_run && r_wrap;
      access_busy    <= (w_acc_next != A_IDLE);
      access_gate    <= w_run && (r_acc_state == A_GATE) &&
                        (r_count >= PULSE_END) && (r_count < GATE_END);
      access_done    <= w_done_next;
      access_error   <= w_error_next;
    end
  end

endmodule
